// File: rtl/audio_i2s_out.sv
// PSG + PCM stereo mixer with saturation, and the I2S serializer that owns the frame timebase.
// One frame is 64 BCK periods; next_sample pulses at each frame start.
module audio_i2s_out #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        enable,
   input  logic [15:0] psg_left,
   input  logic [15:0] psg_right,
   input  logic [15:0] pcm_left,
   input  logic [15:0] pcm_right,
   output logic        next_sample,
   output logic        i2s_bck,
   output logic        i2s_lrck,
   output logic        i2s_data
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [7:0]  div_cnt;
   logic [5:0]  bit_cnt;
   logic [5:0]  bit_nxt;
   logic [15:0] mix_l;
   logic [15:0] mix_r;
   logic [15:0] left_hold;
   logic [15:0] right_hold;
   logic [3:0]  l_idx;
   logic [3:0]  r_idx;
   logic        shift_ev;
   logic        data_nxt;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {a[15], a} + {b[15], b};
      if (sum[16] != sum[15])
         sat_add = sum[16] ? 16'h8000 : 16'h7FFF;
      else
         sat_add = sum[15:0];
   endfunction

   // Shift event is the bck 1->0 transition; bit_nxt is the slot position it enters.
   always_comb begin
      shift_ev = (div_cnt == DIV_LAST) && i2s_bck;
      bit_nxt  = bit_cnt + 6'd1;
      l_idx    = 4'(6'd16 - bit_nxt);
      r_idx    = 4'(6'd48 - bit_nxt);
      data_nxt = 1'b0;
      if (bit_nxt >= 6'd1 && bit_nxt <= 6'd16)
         data_nxt = left_hold[l_idx];
      else if (bit_nxt >= 6'd33 && bit_nxt <= 6'd48)
         data_nxt = right_hold[r_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mix_l <= '0;
         mix_r <= '0;
      end else begin
         mix_l <= sat_add(psg_left, pcm_left);
         mix_r <= sat_add(psg_right, pcm_right);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt     <= '0;
         bit_cnt     <= '1;
         i2s_bck     <= 1'b0;
         i2s_lrck    <= 1'b0;
         i2s_data    <= 1'b0;
         next_sample <= 1'b0;
      end else if (!enable) begin
         div_cnt     <= '0;
         bit_cnt     <= '1;
         i2s_bck     <= 1'b0;
         i2s_lrck    <= 1'b0;
         i2s_data    <= 1'b0;
         next_sample <= 1'b0;
      end else begin
         next_sample <= 1'b0;
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            i2s_bck <= ~i2s_bck;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end
         if (shift_ev) begin
            bit_cnt  <= bit_nxt;
            i2s_lrck <= bit_nxt[5];
            i2s_data <= data_nxt;
            if (bit_nxt == '0)
               next_sample <= 1'b1;
         end
      end
   end

   // Holds survive enable drops; only rst clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left_hold  <= '0;
         right_hold <= '0;
      end else if (enable && shift_ev && bit_nxt == '0) begin
         left_hold  <= mix_l;
         right_hold <= mix_r;
      end
   end

endmodule
